// File: rtl/vga_char_buffer_if.sv
// Write/clear control bus between a text producer and the character buffer.
// Latency: n/a (signal bundle only).
// Backpressure: producer holds wr_valid/wr_addr/wr_char until wr_ready is seen high.
//
// Signals:
//   wr_valid  producer -> buffer  write request
//   wr_ready  buffer -> producer  write port can accept a request
//   wr_addr   producer -> buffer  cell index to write
//   wr_char   producer -> buffer  7-bit character code
//   clr_req   producer -> buffer  single-cycle full-screen clear request
//   busy      buffer -> producer  clear in progress
interface vga_char_buffer_if;
   logic       wr_valid;
   logic       wr_ready;
   logic [7:0] wr_addr;
   logic [6:0] wr_char;
   logic       clr_req;
   logic       busy;

   modport master (
      output wr_valid, wr_addr, wr_char, clr_req,
      input  wr_ready, busy
   );

   modport slave (
      input  wr_valid, wr_addr, wr_char, clr_req,
      output wr_ready, busy
   );
endinterface

// File: rtl/vga_char_buffer.sv
// Character cell buffer feeding a glyph drawer through an external synchronous font ROM.
// Latency: text_xy/text_line to char_pixel is a fixed 3 cycles, one new read per cycle.
// Backpressure: wr_ready low for the whole clear (CELLS cycles after reset or clr_req).
//
// Ports:
//   clk, rst          clock; synchronous active-low reset
//   text_xy/text_line read cell index and glyph line from the drawer
//   font_addr         {char_code, line} to the font ROM (registered)
//   font_data         font ROM data, one cycle after font_addr
//   char_pixel        registered glyph row, bit 7 = leftmost pixel
//   bus               write/clear control bus (slave side)
module vga_char_buffer #(
   parameter int         COLS      = 12,
   parameter int         ROWS      = 13,
   parameter logic [6:0] FILL_CHAR = 7'h20
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [7:0]          text_xy,
   input  logic [3:0]          text_line,
   output logic [10:0]         font_addr,
   input  logic [7:0]          font_data,
   output logic [7:0]          char_pixel,
   vga_char_buffer_if.slave    bus
);

   localparam int         CELLS   = COLS * ROWS;
   localparam logic [8:0] CELLS_W = 9'(CELLS);
   localparam logic [7:0] LAST    = 8'(CELLS - 1);

   typedef enum logic {CLEAR, IDLE} state_t;

   state_t     state_q, state_d;
   logic [7:0] clr_cnt_q, clr_cnt_d;

   logic [6:0] mem [CELLS];
   logic       mem_we;
   logic [7:0] mem_waddr;
   logic [6:0] mem_wdat;

   logic [6:0] code_q;
   logic [3:0] line_q;

   // Both outputs decode registered state only, so neither wr_valid nor
   // clr_req can reach them combinationally.
   assign bus.wr_ready = (state_q == IDLE);
   assign bus.busy     = (state_q == CLEAR);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= CLEAR;
         clr_cnt_q <= 8'd0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      mem_we    = 1'b0;
      mem_waddr = bus.wr_addr;
      mem_wdat  = bus.wr_char;
      case (state_q)
         CLEAR: begin
            // Writes and clear requests are ignored; the sweep runs to completion.
            mem_we    = 1'b1;
            mem_waddr = clr_cnt_q;
            mem_wdat  = FILL_CHAR;
            if (clr_cnt_q == LAST) begin
               state_d   = IDLE;
               clr_cnt_d = 8'd0;
            end else begin
               clr_cnt_d = clr_cnt_q + 8'd1;
            end
         end
         IDLE: begin
            // Out-of-range writes still complete the handshake but touch nothing.
            mem_we = bus.wr_valid && ({1'b0, bus.wr_addr} < CELLS_W);
            // A write in the same cycle as clr_req lands first, then gets cleared.
            if (bus.clr_req) begin
               state_d   = CLEAR;
               clr_cnt_d = 8'd0;
            end
         end
         default: begin
            state_d   = CLEAR;
            clr_cnt_d = 8'd0;
         end
      endcase
   end

   // Gating with rst aborts any write on the reset edge; contents are
   // rebuilt by the clear that follows release.
   always_ff @(posedge clk) begin
      if (rst && mem_we)
         mem[mem_waddr] <= mem_wdat;
   end

   // Read pipeline: stage 1 here, stage 2 is the external ROM, stage 3 below.
   // The array read samples the pre-edge contents, so a same-cycle write to the
   // same cell is seen only from the following read.
   always_ff @(posedge clk) begin
      if (!rst) begin
         code_q     <= 7'd0;
         line_q     <= 4'd0;
         char_pixel <= 8'h00;
      end else begin
         code_q     <= ({1'b0, text_xy} < CELLS_W) ? mem[text_xy] : FILL_CHAR;
         line_q     <= text_line;
         char_pixel <= font_data;
      end
   end

   assign font_addr = {code_q, line_q};

endmodule

// File: tb/tb_vga_char_buffer.sv
module tb_vga_char_buffer;

   localparam int NCELLS = 156;

   logic        clk;
   logic        rst;
   logic [7:0]  text_xy;
   logic [3:0]  text_line;
   logic [10:0] font_addr;
   logic [7:0]  font_data;
   logic [7:0]  char_pixel;

   vga_char_buffer_if bus ();

   vga_char_buffer dut (
      .clk        (clk),
      .rst        (rst),
      .text_xy    (text_xy),
      .text_line  (text_line),
      .font_addr  (font_addr),
      .font_data  (font_data),
      .char_pixel (char_pixel),
      .bus        (bus)
   );

   int tests = 0;
   int fails = 0;

   logic [6:0] model [NCELLS];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Arbitrary but address-dependent font contents.
   function automatic logic [7:0] rom_f(input logic [10:0] a);
      return a[7:0] ^ {a[10:8], a[10:6]} ^ 8'hA5;
   endfunction

   // External synchronous font ROM.
   always @(posedge clk) font_data <= rom_f(font_addr);

   // Code the drawer should see for a cell: stored value, or blank outside the screen.
   function automatic logic [6:0] ref_code(input logic [7:0] xy);
      if (int'(xy) < NCELLS) return model[xy];
      return 7'h20;
   endfunction

   function automatic void model_blank();
      for (int i = 0; i < NCELLS; i++) model[i] = 7'h20;
   endfunction

   // Streams n reads, one per cycle, checking font_addr one cycle and
   // char_pixel three cycles after each address is presented.
   task automatic test_readback(input string tag, input int n, input bit rnd, input int base);
      logic [10:0] hist [$];
      logic [7:0]  xy;
      logic [3:0]  ln;
      for (int i = 0; i < n + 3; i++) begin
         @(negedge clk);
         if (i >= 1 && i - 1 < n) begin
            tests++;
            if (font_addr !== hist[i-1]) begin
               fails++;
               $display("FAIL %s font_addr rd=%0d got %h exp %h", tag, i-1, font_addr, hist[i-1]);
            end
         end
         if (i >= 3) begin
            tests++;
            if (char_pixel !== rom_f(hist[i-3])) begin
               fails++;
               $display("FAIL %s char_pixel rd=%0d got %h exp %h", tag, i-3, char_pixel, rom_f(hist[i-3]));
            end
         end
         if (i < n) begin
            xy = rnd ? 8'($urandom_range(0, 255)) : 8'(base + i);
            ln = 4'($urandom_range(0, 15));
            text_xy   = xy;
            text_line = ln;
            hist.push_back({ref_code(xy), ln});
         end
      end
   endtask

   task automatic write1(input string tag, input logic [7:0] a, input logic [6:0] c);
      @(negedge clk);
      tests++;
      if (bus.wr_ready !== 1'b1) begin
         fails++;
         $display("FAIL %s wr_ready got %b exp 1", tag, bus.wr_ready);
      end
      bus.wr_valid = 1'b1;
      bus.wr_addr  = a;
      bus.wr_char  = c;
      if (int'(a) < NCELLS) model[a] = c;
      @(negedge clk);
      bus.wr_valid = 1'b0;
   endtask

   task automatic test_reset();
      int n;
      rst = 1'b0;
      bus.wr_valid = 1'b0; bus.clr_req = 1'b0; bus.wr_addr = 8'd0; bus.wr_char = 7'd0;
      text_xy = 8'd0; text_line = 4'd0;
      repeat (3) @(negedge clk);
      tests += 4;
      if (bus.busy !== 1'b1)       begin fails++; $display("FAIL reset busy got %b exp 1", bus.busy); end
      if (bus.wr_ready !== 1'b0)   begin fails++; $display("FAIL reset wr_ready got %b exp 0", bus.wr_ready); end
      if (char_pixel !== 8'h00)    begin fails++; $display("FAIL reset char_pixel got %h exp 00", char_pixel); end
      if (font_addr !== 11'h000)   begin fails++; $display("FAIL reset font_addr got %h exp 000", font_addr); end
      rst = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (bus.busy && n < 400);
      tests += 2;
      if (n != NCELLS)           begin fails++; $display("FAIL reset busy_len got %0d exp %0d", n, NCELLS); end
      if (bus.wr_ready !== 1'b1) begin fails++; $display("FAIL reset ready_after got %b exp 1", bus.wr_ready); end
      model_blank();
      test_readback("reset_rd", NCELLS, 1'b0, 0);
   endtask

   task automatic test_basic();
      write1("basic_wr", 8'd25, 7'h35);
      @(negedge clk);
      text_xy = 8'd25; text_line = 4'd3;
      @(negedge clk);
      tests++;
      if (font_addr !== 11'h353) begin fails++; $display("FAIL basic font_addr got %h exp 353", font_addr); end
      @(negedge clk);
      @(negedge clk);
      tests++;
      if (char_pixel !== rom_f(11'h353)) begin
         fails++; $display("FAIL basic char_pixel got %h exp %h", char_pixel, rom_f(11'h353));
      end
   endtask

   task automatic test_back_to_back();
      logic [6:0] c;
      for (int i = 0; i < NCELLS; i++) begin
         @(negedge clk);
         tests++;
         if (bus.wr_ready !== 1'b1) begin fails++; $display("FAIL b2b stall at %0d", i); end
         c = 7'($urandom);
         bus.wr_valid = 1'b1; bus.wr_addr = 8'(i); bus.wr_char = c;
         model[i] = c;
      end
      @(negedge clk);
      bus.wr_valid = 1'b0;
      test_readback("b2b_rd", NCELLS, 1'b0, 0);
   endtask

   task automatic test_out_of_range();
      write1("oor_wr", 8'd200, 7'h4A);
      test_readback("oor_cells", NCELLS, 1'b0, 0);
      @(negedge clk);
      text_xy = 8'd200; text_line = 4'd0;
      @(negedge clk);
      tests++;
      if (font_addr !== 11'h200) begin fails++; $display("FAIL oor_rd font_addr got %h exp 200", font_addr); end
   endtask

   task automatic test_same_cycle();
      logic [6:0] old_c, new_c;
      logic [3:0] ln;
      old_c = model[7];
      new_c = old_c ^ 7'h55;
      ln = 4'($urandom_range(0, 15));
      @(negedge clk);
      bus.wr_valid = 1'b1; bus.wr_addr = 8'd7; bus.wr_char = new_c;
      text_xy = 8'd7; text_line = ln;
      model[7] = new_c;
      @(negedge clk);
      bus.wr_valid = 1'b0;
      tests++;
      if (font_addr !== {old_c, ln}) begin fails++; $display("FAIL rw_same old got %h exp %h", font_addr, {old_c, ln}); end
      @(negedge clk);
      tests++;
      if (font_addr !== {new_c, ln}) begin fails++; $display("FAIL rw_same new got %h exp %h", font_addr, {new_c, ln}); end
   endtask

   task automatic test_random();
      logic [7:0] a;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         tests++;
         if (bus.wr_ready !== 1'b1) begin fails++; $display("FAIL rnd wr_ready got %b exp 1", bus.wr_ready); end
         a = 8'($urandom_range(0, 255));
         bus.wr_valid = 1'($urandom);
         bus.wr_addr  = a;
         bus.wr_char  = 7'($urandom);
         if (bus.wr_valid && int'(a) < NCELLS) model[a] = bus.wr_char;
      end
      @(negedge clk);
      bus.wr_valid = 1'b0;
      test_readback("rnd_rd", 120, 1'b1, 0);
   endtask

   task automatic test_clear();
      int n;
      @(negedge clk);
      tests++;
      if (bus.wr_ready !== 1'b1) begin fails++; $display("FAIL clr wr_ready got %b exp 1", bus.wr_ready); end
      bus.wr_valid = 1'b1; bus.wr_addr = 8'd5; bus.wr_char = 7'h11;
      bus.clr_req = 1'b1;
      n = 0;
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         if (!bus.busy) break;
         n++;
         tests++;
         if (bus.wr_ready !== 1'b0) begin fails++; $display("FAIL clr ready_in_clear got %b exp 0", bus.wr_ready); end
         bus.clr_req  = (n == 51);
         bus.wr_valid = 1'b1;
         bus.wr_addr  = 8'($urandom_range(0, NCELLS - 1));
         bus.wr_char  = 7'($urandom);
      end
      bus.wr_valid = 1'b0; bus.clr_req = 1'b0;
      tests++;
      if (n != NCELLS) begin fails++; $display("FAIL clr busy_len got %0d exp %0d", n, NCELLS); end
      model_blank();
      test_readback("clr_rd", NCELLS, 1'b0, 0);
   endtask

   task automatic test_reset_mid();
      int n;
      // Reset at clear cycle 80.
      @(negedge clk);
      bus.clr_req = 1'b1;
      @(negedge clk);
      bus.clr_req = 1'b0;
      repeat (80) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      tests += 3;
      if (char_pixel !== 8'h00) begin fails++; $display("FAIL rstmid char_pixel got %h exp 00", char_pixel); end
      if (bus.busy !== 1'b1)    begin fails++; $display("FAIL rstmid busy got %b exp 1", bus.busy); end
      if (font_addr !== 11'h0)  begin fails++; $display("FAIL rstmid font_addr got %h exp 000", font_addr); end
      rst = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (bus.busy && n < 400);
      tests++;
      if (n != NCELLS) begin fails++; $display("FAIL rstmid busy_len got %0d exp %0d", n, NCELLS); end

      // Reset in the middle of a write burst.
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         bus.wr_valid = 1'b1; bus.wr_addr = 8'(i); bus.wr_char = 7'($urandom);
         if (i == 10) rst = 1'b0;
      end
      tests++;
      if (char_pixel !== 8'h00) begin fails++; $display("FAIL rstburst char_pixel got %h exp 00", char_pixel); end
      @(negedge clk);
      rst = 1'b1; bus.wr_valid = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (bus.busy && n < 400);
      tests++;
      if (n != NCELLS) begin fails++; $display("FAIL rstburst busy_len got %0d exp %0d", n, NCELLS); end
      model_blank();
      test_readback("rstburst_rd", NCELLS, 1'b0, 0);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_out_of_range();
      test_same_cycle();
      test_random();
      test_clear();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
